// File: rtl/dot_product_accum.sv
// Accumulates TERMS unsigned 16-bit products into one ACC_W-bit result and
// holds it behind a valid/ready handshake until downstream consumes it.
module dot_product_accum #(
    parameter int TERMS = 4,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [15:0]      prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ready
);

    // count only needs to reach TERMS-1; the final accept clears it.
    localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic               running;
    logic [ACC_W-1:0]   acc, acc_next, acc_sum;
    logic [CNT_W-1:0]   count, count_next;
    logic               accept, last_term, load_sum;

    // running holds prod_ready low until the first edge after reset release.
    assign prod_ready = running && (state != HOLD);
    assign sum_valid  = (state == HOLD);
    assign accept     = prod_valid && prod_ready;
    assign last_term  = (count == CNT_W'(TERMS - 1));
    assign acc_sum    = acc + ACC_W'(prod);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        acc_next   = acc;
        count_next = count;
        load_sum   = 1'b0;
        case (state)
            HOLD: begin
                if (sum_ready) state_next = IDLE;
            end
            default: begin
                if (clear) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    count_next = '0;
                end else if (accept) begin
                    if (last_term) begin
                        state_next = HOLD;
                        load_sum   = 1'b1;
                        acc_next   = '0;
                        count_next = '0;
                    end else begin
                        state_next = ACCUM;
                        acc_next   = acc_sum;
                        count_next = count + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state   <= IDLE;
            running <= 1'b0;
            acc     <= '0;
            count   <= '0;
        end else begin
            state   <= state_next;
            running <= 1'b1;
            acc     <= acc_next;
            count   <= count_next;
        end
    end

    // sum keeps its last value after handoff; only sum_valid qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (load_sum) begin
            sum <= acc_sum;
        end
    end

endmodule

// File: tb/tb_dot_product_accum.sv
// Directed bench for dot_product_accum (TERMS=4, ACC_W=18): expected sums go
// into a queue and a negedge monitor compares them at each result handoff.
module tb_dot_product_accum;

    localparam int TERMS = 4;
    localparam int ACC_W = 18;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic [15:0]      prod;
    logic             prod_valid;
    logic             prod_ready;
    logic [ACC_W-1:0] sum;
    logic             sum_valid;
    logic             sum_ready;

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0] exp_q[$];

    dot_product_accum #(.TERMS(TERMS), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .prod      (prod),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .sum       (sum),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        logic [15:0] v[4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            prod       = v[i];
            prod_valid = 1'b1;
            step();
        end
        prod_valid = 1'b0;
    endtask

    // Monitor: a handoff is sum_valid & sum_ready seen mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sum_valid === 1'b1 && sum_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got sum %0d, expected no result", sum);
            end else begin
                check("sb_sum", 32'(sum), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        prod       = '0;
        prod_valid = 1'b0;
        sum_ready  = 1'b1;
        #1;
        check("rst_prod_ready", 32'(prod_ready), 0);
        check("rst_sum_valid", 32'(sum_valid), 0);
        check("rst_sum", 32'(sum), 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("release_ready_before_edge", 32'(prod_ready), 0);
        step();
        check("idle_prod_ready", 32'(prod_ready), 1);
        check("idle_sum_valid", 32'(sum_valid), 0);
        check("idle_sum", 32'(sum), 0);

        // 72+72+100+5 = 249, valid exactly one cycle after the 4th accept
        exp_q.push_back(249);
        for (int i = 0; i < 3; i++) begin
            prod       = (i == 2) ? 16'd100 : 16'd72;
            prod_valid = 1'b1;
            step();
        end
        check("latency_not_early", 32'(sum_valid), 0);
        prod = 16'd5;
        step();
        prod_valid = 1'b0;
        check("latency_valid", 32'(sum_valid), 1);
        check("latency_sum", 32'(sum), 249);
        check("latency_hold_ready", 32'(prod_ready), 0);
        step();
        check("one_cycle_valid", 32'(sum_valid), 0);
        check("after_ready", 32'(prod_ready), 1);

        // 4 * 65025 = 260100, fits 18 bits
        exp_q.push_back(260100);
        send4(16'd65025, 16'd65025, 16'd65025, 16'd65025);
        step();

        // Back-pressure: held result, stalled producer
        sum_ready = 1'b0;
        exp_q.push_back(249);
        send4(16'd72, 16'd72, 16'd100, 16'd5);
        prod       = 16'd999;
        prod_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(sum_valid), 1);
            check("stall_sum", 32'(sum), 249);
            check("stall_ready", 32'(prod_ready), 0);
            step();
        end
        prod_valid = 1'b0;
        sum_ready  = 1'b1;
        step();
        check("handoff_valid_drop", 32'(sum_valid), 0);
        check("handoff_ready", 32'(prod_ready), 1);
        check("sum_retained", 32'(sum), 249);
        exp_q.push_back(10);
        send4(16'd1, 16'd2, 16'd3, 16'd4);
        step();

        // clear discards partial 10+20 and the same-cycle 30
        exp_q.push_back(4);
        prod = 16'd10; prod_valid = 1'b1; step();
        prod = 16'd20; step();
        prod = 16'd30; clear = 1'b1; step();
        clear = 1'b0;
        prod_valid = 1'b0;
        send4(16'd1, 16'd1, 16'd1, 16'd1);
        step();

        // clear in HOLD is ignored
        sum_ready = 1'b0;
        exp_q.push_back(15);
        send4(16'd1, 16'd2, 16'd4, 16'd8);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("hold_clear_valid", 32'(sum_valid), 1);
        check("hold_clear_sum", 32'(sum), 15);
        sum_ready = 1'b1;
        step();

        // gaps with prod toggling but valid low
        exp_q.push_back(6);
        prod = 16'd1; prod_valid = 1'b1; step();
        prod = 16'd77; prod_valid = 1'b0; step(); step();
        prod = 16'd2; prod_valid = 1'b1; step();
        prod = 16'd88; prod_valid = 1'b0; step();
        prod = 16'd3; prod_valid = 1'b1; step();
        prod = 16'd0; step();
        prod_valid = 1'b0;
        step();

        // async reset while in HOLD
        sum_ready = 1'b0;
        send4(16'd72, 16'd72, 16'd100, 16'd5);
        check("pre_reset_sum", 32'(sum), 249);
        #2 rst_n = 1'b0;
        #1;
        check("async_sum_valid", 32'(sum_valid), 0);
        check("async_sum", 32'(sum), 0);
        check("async_ready", 32'(prod_ready), 0);
        step();
        rst_n = 1'b1;
        step();

        // async reset mid-ACCUM discards the partial sum
        prod = 16'd50; prod_valid = 1'b1; step();
        step();
        prod_valid = 1'b0;
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_valid", 32'(sum_valid), 0);
        sum_ready = 1'b1;
        exp_q.push_back(4);
        send4(16'd1, 16'd1, 16'd1, 16'd1);
        step();
        step();

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
